// File: rtl/dm_responder.sv
// Data-memory slave with req/ready handshake, WAIT wait states and byte-enabled writes.
// Define DM_RESPONDER_ERR_EN to enable misalignment/range error responses.
module dm_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;
  logic [31:0] mem [DEPTH];

  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  logic [AW-1:0] widx;
  logic        fault;
  logic        go_resp;

  // With WAIT=0 the response is entered on the accepting edge, so the
  // transaction fields come straight from the ports while in IDLE.
  always_comb begin
    t_we    = (state == S_IDLE) ? we    : l_we;
    t_addr  = (state == S_IDLE) ? addr  : l_addr;
    t_wdata = (state == S_IDLE) ? wdata : l_wdata;
    t_be    = (state == S_IDLE) ? be    : l_be;
    widx    = t_addr[AW+1:2];
  end

`ifdef DM_RESPONDER_ERR_EN
  assign fault = (t_addr[1:0] != 2'b00) || (|t_addr[31:AW+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{t_addr[31:AW+2], t_addr[1:0]};
  assign fault = 1'b0;
`endif

  assign go_resp = rst_n &&
                   (((state == S_IDLE) && req && (WAIT == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_be    <= '0;
    end else begin
      ready <= go_resp;
      err   <= go_resp && fault;
      rdata <= (go_resp && !t_we && !fault) ? mem[widx] : '0;
      case (state)
        S_IDLE: if (req) begin
          l_we    <= we;
          l_addr  <= addr;
          l_wdata <= wdata;
          l_be    <= be;
          cnt     <= 4'(WAIT);
          state   <= (WAIT == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is intentionally not reset; go_resp is gated by rst_n so an
  // in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (go_resp && t_we && !fault)
      for (int i = 0; i < 4; i++)
        if (t_be[i]) mem[widx][8*i +: 8] <= t_wdata[8*i +: 8];
  end
endmodule
